// File: rtl/stroke_interpolator.sv
// Joins successive centre-of-mass points with Bresenham lines and streams one
// frame-buffer address per pixel over a valid/ready handshake.
module stroke_interpolator #(
  parameter int unsigned H_PIXELS = 320,
  parameter int unsigned V_PIXELS = 240,
  parameter int unsigned MAX_JUMP = 64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] x_com_in,
  input  logic [9:0]  y_com_in,
  input  logic        com_valid_in,
  input  logic        pen_down_in,
  output logic [16:0] pixel_addr_out,
  output logic        pixel_valid_out,
  input  logic        pixel_ready_in,
  output logic        busy_out,
  output logic        dropped_out
);

  typedef enum logic [1:0] {StIdle, StSetup, StDraw} state_e;

  state_e             state_q, state_d;
  logic               has_prev_q, has_prev_d;
  logic [10:0]        prev_x_q, prev_x_d;
  logic [9:0]         prev_y_q, prev_y_d;
  logic [10:0]        tgt_x_q, tgt_x_d;
  logic [9:0]         tgt_y_q, tgt_y_d;
  logic [10:0]        cur_x_q, cur_x_d;
  logic [9:0]         cur_y_q, cur_y_d;
  logic signed [12:0] dx_q, dx_d;
  logic signed [12:0] dy_q, dy_d;
  logic signed [12:0] err_q, err_d;
  logic               sx_neg_q, sx_neg_d;
  logic               sy_neg_q, sy_neg_d;
  logic [16:0]        addr_q, addr_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               dropped_q, dropped_d;

  function automatic logic [16:0] addr_of(input logic [10:0] x, input logic [9:0] y);
    if (H_PIXELS == 320) begin
      return ({7'd0, y} << 8) + ({7'd0, y} << 6) + {6'd0, x};
    end else begin
      return 17'((32'(y) * H_PIXELS) + 32'(x));
    end
  endfunction

  // Input clamp
  logic [10:0] x_clamp;
  logic [9:0]  y_clamp;
  always_comb begin
    x_clamp = (32'(x_com_in) > (H_PIXELS - 1)) ? 11'(H_PIXELS - 1) : x_com_in;
    y_clamp = (32'(y_com_in) > (V_PIXELS - 1)) ? 10'(V_PIXELS - 1) : y_com_in;
  end

  // Segment geometry from prev to target, used in SETUP
  logic signed [12:0] diff_x, diff_y;
  logic [12:0]        adx, ady;
  logic               jump;
  logic signed [12:0] setup_dx, setup_dy;
  always_comb begin
    diff_x   = $signed({2'b00, tgt_x_q}) - $signed({2'b00, prev_x_q});
    diff_y   = $signed({3'b000, tgt_y_q}) - $signed({3'b000, prev_y_q});
    adx      = diff_x[12] ? $unsigned(-diff_x) : $unsigned(diff_x);
    ady      = diff_y[12] ? $unsigned(-diff_y) : $unsigned(diff_y);
    jump     = !has_prev_q || (adx > 13'(MAX_JUMP)) || (ady > 13'(MAX_JUMP));
    setup_dx = $signed(adx);
    setup_dy = -$signed(ady);
  end

  // One Bresenham step; SETUP steps from prev, DRAW from the current point
  logic [10:0]        st_x, nx;
  logic [9:0]         st_y, ny;
  logic signed [12:0] st_err, st_dx, st_dy, nerr;
  logic               st_sx_neg, st_sy_neg;
  logic signed [13:0] e2;
  logic               step_x, step_y;
  always_comb begin
    if (state_q == StSetup) begin
      st_x      = prev_x_q;
      st_y      = prev_y_q;
      st_err    = setup_dx + setup_dy;
      st_dx     = setup_dx;
      st_dy     = setup_dy;
      st_sx_neg = diff_x[12];
      st_sy_neg = diff_y[12];
    end else begin
      st_x      = cur_x_q;
      st_y      = cur_y_q;
      st_err    = err_q;
      st_dx     = dx_q;
      st_dy     = dy_q;
      st_sx_neg = sx_neg_q;
      st_sy_neg = sy_neg_q;
    end
    e2     = $signed({st_err, 1'b0});
    step_x = e2 >= $signed({st_dy[12], st_dy});
    step_y = e2 <= $signed({st_dx[12], st_dx});
    nerr   = st_err + (step_x ? st_dy : 13'sd0) + (step_y ? st_dx : 13'sd0);
    nx     = step_x ? (st_sx_neg ? st_x - 11'd1 : st_x + 11'd1) : st_x;
    ny     = step_y ? (st_sy_neg ? st_y - 10'd1 : st_y + 10'd1) : st_y;
  end

  logic at_target;
  assign at_target = (cur_x_q == tgt_x_q) && (cur_y_q == tgt_y_q);

  always_comb begin
    state_d    = state_q;
    has_prev_d = has_prev_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    tgt_x_d    = tgt_x_q;
    tgt_y_d    = tgt_y_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    err_d      = err_q;
    sx_neg_d   = sx_neg_q;
    sy_neg_d   = sy_neg_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    dropped_d  = com_valid_in && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (com_valid_in) begin
          if (pen_down_in) begin
            tgt_x_d = x_clamp;
            tgt_y_d = y_clamp;
            state_d = StSetup;
          end else begin
            has_prev_d = 1'b0;
            prev_x_d   = x_clamp;
            prev_y_d   = y_clamp;
          end
        end
      end
      StSetup: begin
        if (jump) begin
          cur_x_d = tgt_x_q;
          cur_y_d = tgt_y_q;
          addr_d  = addr_of(tgt_x_q, tgt_y_q);
          valid_d = 1'b1;
          state_d = StDraw;
        end else if ((adx == 13'd0) && (ady == 13'd0)) begin
          state_d = StIdle;
        end else begin
          dx_d     = setup_dx;
          dy_d     = setup_dy;
          sx_neg_d = diff_x[12];
          sy_neg_d = diff_y[12];
          err_d    = nerr;
          cur_x_d  = nx;
          cur_y_d  = ny;
          addr_d   = addr_of(nx, ny);
          valid_d  = 1'b1;
          state_d  = StDraw;
        end
      end
      StDraw: begin
        if (valid_q && pixel_ready_in) begin
          if (at_target) begin
            valid_d    = 1'b0;
            prev_x_d   = tgt_x_q;
            prev_y_d   = tgt_y_q;
            has_prev_d = 1'b1;
            state_d    = StIdle;
          end else begin
            err_d   = nerr;
            cur_x_d = nx;
            cur_y_d = ny;
            addr_d  = addr_of(nx, ny);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      has_prev_q <= 1'b0;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      has_prev_q <= has_prev_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      err_q      <= err_d;
      sx_neg_q   <= sx_neg_d;
      sy_neg_q   <= sy_neg_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  assign pixel_addr_out  = addr_q;
  assign pixel_valid_out = valid_q;
  assign busy_out        = busy_q;
  assign dropped_out     = dropped_q;

endmodule

// File: tb/tb_stroke_interpolator.sv
// Directed-vector bench for stroke_interpolator; expected addresses are hand-computed.
module tb_stroke_interpolator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] x_com = '0;
  logic [9:0]  y_com = '0;
  logic        com_valid = 1'b0;
  logic        pen_down = 1'b1;
  logic [16:0] addr;
  logic        valid;
  logic        ready = 1'b1;
  logic        busy;
  logic        dropped;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  stroke_interpolator dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .x_com_in        (x_com),
    .y_com_in        (y_com),
    .com_valid_in    (com_valid),
    .pen_down_in     (pen_down),
    .pixel_addr_out  (addr),
    .pixel_valid_out (valid),
    .pixel_ready_in  (ready),
    .busy_out        (busy),
    .dropped_out     (dropped)
  );

  task automatic check_eq(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic send(input int x, input int y, input bit pen);
    @(posedge clk);
    #1;
    x_com     = 11'(x);
    y_com     = 10'(y);
    pen_down  = pen;
    com_valid = 1'b1;
    @(posedge clk);
    #1;
    com_valid = 1'b0;
    pen_down  = 1'b1;
  endtask

  // Runs from the SETUP cycle until busy drops, checking each transfer against exp_q.
  task automatic collect(input string tag, input int stall_at, input bit poke);
    int n = 0;
    int first = -1;
    int last = -1;
    int drops = 0;
    int idx;
    int exp_n;
    bit stalled = 1'b0;
    logic [16:0] held;
    exp_n = exp_q.size();
    for (idx = 0; idx < 300; idx++) begin
      @(negedge clk);
      if (dropped) drops++;
      if (poke) com_valid = (idx == 5);
      if (valid && (n == stall_at) && !stalled) begin
        stalled = 1'b1;
        ready   = 1'b0;
        held    = addr;
        repeat (5) begin
          @(negedge clk);
          check_eq({tag, " stall addr"}, int'(addr), int'(held));
          check_eq({tag, " stall valid"}, int'(valid), 1);
        end
        ready = 1'b1;
        idx += 5;
      end
      if (valid && ready) begin
        if (exp_q.size() > 0) check_eq({tag, " addr"}, int'(addr), exp_q.pop_front());
        else check_eq({tag, " extra pixel"}, int'(addr), -1);
        n++;
        if (first < 0) first = idx;
        last = idx;
      end
      if (!busy) break;
    end
    check_eq({tag, " timeout"}, int'(idx >= 300), 0);
    check_eq({tag, " count"}, n, exp_n);
    check_eq({tag, " drops"}, drops, poke ? 1 : 0);
    if (exp_n > 0) begin
      check_eq({tag, " latency"}, first, 1);
      check_eq({tag, " busy end"}, idx, last + 1);
    end
    exp_q.delete();
  endtask

  initial begin
    #12;
    check_eq("reset addr", int'(addr), 0);
    check_eq("reset valid", int'(valid), 0);
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset dropped", int'(dropped), 0);
    rst_n = 1'b1;

    send(100, 50, 1'b1);
    exp_q = '{16100};
    collect("first", -1, 1'b0);

    send(103, 50, 1'b1);
    exp_q = '{16101, 16102, 16103};
    collect("horiz", -1, 1'b0);

    send(104, 52, 1'b1);
    exp_q = '{16424, 16744};
    collect("steep", -1, 1'b0);

    send(108, 54, 1'b1);
    exp_q = '{17065, 17066, 17387, 17388};
    collect("stall", 2, 1'b0);

    send(10, 10, 1'b1);
    exp_q = '{3210};
    collect("jump1", -1, 1'b0);
    send(200, 10, 1'b1);
    exp_q = '{3400};
    collect("jump2", -1, 1'b0);
    send(200, 10, 1'b1);
    collect("same", -1, 1'b0);

    send(240, 10, 1'b1);
    x_com = 11'd5;
    y_com = 10'd5;
    for (int i = 1; i <= 40; i++) exp_q.push_back(3400 + i);
    collect("long", -1, 1'b1);
    com_valid = 1'b0;

    send(50, 50, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("penup busy", int'(busy), 0);
    check_eq("penup valid", int'(valid), 0);
    send(52, 50, 1'b1);
    exp_q = '{16052};
    collect("penup", -1, 1'b0);

    send(400, 300, 1'b1);
    exp_q = '{76799};
    collect("clamp", -1, 1'b0);

    send(300, 239, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("mid valid", int'(valid), 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst addr", int'(addr), 0);
    check_eq("arst valid", int'(valid), 0);
    check_eq("arst busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(310, 239, 1'b1);
    exp_q = '{76790};
    collect("after rst", -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
